shift_divider: RTL and testbench

SHIFT_DIVIDER -- requirements
Module: shift_divider

---
 rtl/shift_divider.sv | 105 ++++++++++
 tb/tb_shift_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_divider.sv
// Restoring, MSB-first sequential divider for unsigned N-bit operands.
// One quotient bit per clock; results are held in output registers until the next completion.
module shift_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dvs;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_remOut;
    logic          r_divZero;

    logic [N+1:0]  w_shifted;
    logic [N:0]    w_trial;
    logic          w_ge;
    logic [N:0]    w_remNext;
    logic [N-1:0]  w_dvdNext;

    // The dividend register doubles as the quotient: its MSB moves into the
    // remainder while the new quotient bit enters at its LSB.
    always_comb begin
        w_shifted = {r_rem, r_dvd[N-1]};
        w_trial   = w_shifted[N:0] - {1'b0, r_dvs};
        w_ge      = (w_shifted >= {2'b00, r_dvs});
        w_remNext = w_ge ? w_trial : w_shifted[N:0];
        w_dvdNext = {r_dvd[N-2:0], w_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_quot    <= '0;
            r_remOut  <= '0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_rem   <= '0;
                        r_count <= CW'(N);
                        if (divisor == '0) begin
                            r_quot    <= '1;
                            r_remOut  <= dividend;
                            r_divZero <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_remNext;
                    r_dvd   <= w_dvdNext;
                    r_count <= r_count - CW'(1);
                    // Results are published on the last step so they are valid during the done cycle.
                    if (r_count == CW'(1)) begin
                        r_quot    <= w_dvdNext;
                        r_remOut  <= w_remNext[N-1:0];
                        r_divZero <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign quotient  = r_quot;
    assign remainder = r_remOut;
    assign div_zero  = r_divZero;

endmodule

// File: tb/tb_shift_divider.sv
// Self-checking bench: directed N=8 vectors and corner sequences, plus a randomized N=16 sweep.
module tb_shift_divider;

    logic clk;
    logic rst;

    logic       start8;
    logic [7:0] dvd8, dvs8;
    logic       busy8, done8, dz8;
    logic [7:0] q8, r8;

    logic        start16;
    logic [15:0] dvd16, dvs16;
    logic        busy16, done16, dz16;
    logic [15:0] q16, r16;

    int compared;
    int mismatched;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    shift_divider #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_zero(dz8)
    );

    shift_divider #(.N(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_zero(dz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge that raises done.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int lat);
        dvd8   = a;
        dvs8   = b;
        start8 = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        start8 = 1'b0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, output int lat);
        dvd16   = a;
        dvs16   = b;
        start16 = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        start16 = 1'b0;
        while (done16 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic checkPulseEnd8();
        @(posedge clk);
        #1;
        checkOutput("done8_pulse", {63'd0, done8}, 64'd0);
        checkOutput("busy8_idle", {63'd0, busy8}, 64'd0);
    endtask

    initial begin
        int lat;
        int doneCount;
        int doneAt;
        logic [15:0] a16, b16, expQ, expR;
        logic expDz;
        logic okProp;

        compared   = 0;
        mismatched = 0;
        start8 = 0; dvd8 = 0; dvs8 = 0;
        start16 = 0; dvd16 = 0; dvs16 = 0;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
        vecs[2] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 9};
        vecs[3] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1};
        vecs[4] = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 9};
        vecs[5] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 9};
        vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
        vecs[7] = '{8'd7,   8'd255, 8'd0,   8'd7,   1'b0, 9};
        vecs[8] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy8}, 64'd0);
        checkOutput("reset_done", {63'd0, done8}, 64'd0);
        checkOutput("reset_q", {56'd0, q8}, 64'd0);
        checkOutput("reset_r", {56'd0, r8}, 64'd0);
        checkOutput("reset_dz", {63'd0, dz8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed table, N=8");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
            checkOutput($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_q", i), {56'd0, q8}, {56'd0, vecs[i].q});
            checkOutput($sformatf("vec%0d_r", i), {56'd0, r8}, {56'd0, vecs[i].r});
            checkOutput($sformatf("vec%0d_dz", i), {63'd0, dz8}, {63'd0, vecs[i].dz});
            checkOutput($sformatf("vec%0d_busy", i), {63'd0, busy8}, 64'd1);
            checkPulseEnd8();
            checkOutput($sformatf("vec%0d_hold_q", i), {56'd0, q8}, {56'd0, vecs[i].q});
        end

        $display("[TB] back-to-back 255/1 then 3/10");
        dvd8 = 8'd255; dvs8 = 8'd1; start8 = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        checkOutput("b2b1_lat", 64'(lat), 64'd9);
        checkOutput("b2b1_q", {56'd0, q8}, 64'd255);
        checkOutput("b2b1_r", {56'd0, r8}, 64'd0);
        dvd8 = 8'd3; dvs8 = 8'd10;
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_busy", {63'd0, busy8}, 64'd0);
        @(posedge clk);
        lat = 1;
        #1;
        start8 = 1'b0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        checkOutput("b2b2_lat", 64'(lat), 64'd9);
        checkOutput("b2b2_q", {56'd0, q8}, 64'd0);
        checkOutput("b2b2_r", {56'd0, r8}, 64'd3);
        checkPulseEnd8();

        $display("[TB] start and operand changes ignored during CALC");
        dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
        @(posedge clk);
        #1;
        doneCount = 0;
        doneAt    = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd3;
            end else begin
                start8 = 1'b0;
            end
            if (done8 === 1'b1) begin
                doneCount++;
                if (doneAt == 0) begin
                    doneAt = c;
                    checkOutput("ign_q", {56'd0, q8}, 64'd14);
                    checkOutput("ign_r", {56'd0, r8}, 64'd2);
                end
            end
            @(posedge clk);
            #1;
        end
        checkOutput("ign_lat", 64'(doneAt), 64'd9);
        checkOutput("ign_done_count", 64'(doneCount), 64'd1);

        $display("[TB] reset mid-division of 255/16");
        dvd8 = 8'd255; dvs8 = 8'd16; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre_rst_busy", {63'd0, busy8}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", {63'd0, busy8}, 64'd0);
        checkOutput("arst_done", {63'd0, done8}, 64'd0);
        checkOutput("arst_q", {56'd0, q8}, 64'd0);
        checkOutput("arst_r", {56'd0, r8}, 64'd0);
        checkOutput("arst_dz", {63'd0, dz8}, 64'd0);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("start_in_rst", {63'd0, busy8}, 64'd0);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(8'd255, 8'd16, lat);
        checkOutput("post_rst_lat", 64'(lat), 64'd9);
        checkOutput("post_rst_q", {56'd0, q8}, 64'd15);
        checkOutput("post_rst_r", {56'd0, r8}, 64'd15);
        checkPulseEnd8();

        $display("[TB] randomized sweep, N=16");
        for (int k = 0; k < 1000; k++) begin
            a16 = 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                b16 = 16'd0;
            else if ($urandom_range(0, 3) == 0)
                b16 = 16'($urandom_range(1, 255));
            else
                b16 = 16'($urandom);
            if (b16 == 16'd0) begin
                expQ = 16'hFFFF; expR = a16; expDz = 1'b1;
            end else begin
                expQ = a16 / b16; expR = a16 % b16; expDz = 1'b0;
            end
            applyStimulus16(a16, b16, lat);
            checkOutput($sformatf("rnd%0d_%0d/%0d", k, a16, b16),
                        {15'd0, dz16, q16, r16, 16'(lat)},
                        {15'd0, expDz, expQ, expR, (b16 == 16'd0) ? 16'd1 : 16'd17});
            if (b16 != 16'd0) begin
                okProp = ((32'(q16) * 32'(b16) + 32'(r16)) == 32'(a16)) && (r16 < b16);
                checkOutput($sformatf("rnd%0d_identity", k), {63'd0, okProp}, 64'd1);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
